// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: shared load/store encodings, register offsets and CTRL bit indices.
// Ports: none (package). Imported by the timer, its lane unit and, later, data_memory.
package mmio_timer_pkg;
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam logic [5:0] OFF_CTRL    = 6'h00;
    localparam logic [5:0] OFF_STATUS  = 6'h01;
    localparam logic [5:0] OFF_COUNT   = 6'h02;
    localparam logic [5:0] OFF_COMPARE = 6'h03;
    localparam logic [5:0] OFF_PRESC   = 6'h04;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction
endpackage

// File: rtl/mmio_timer_if.sv
// mmio_timer_if: core data-memory bus as seen by a memory-mapped responder.
// Ports: W_en/R_en strobes, addr, RW_type, din (core -> responder); dout, sel (responder -> core).
interface mmio_timer_if;
    logic        W_en;
    logic        R_en;
    logic [31:0] addr;
    logic [2:0]  RW_type;
    logic [31:0] din;
    logic [31:0] dout;
    logic        sel;

    modport master (output W_en, R_en, addr, RW_type, din, input dout, sel);
    modport slave  (input W_en, R_en, addr, RW_type, din, output dout, sel);
endinterface

// File: rtl/mmio_lane_unit.sv
// mmio_lane_unit: combinational byte-lane steering for RISC-V loads and stores.
// Ports: rw_type (funct3), lane (addr[1:0]), rdata (read word), wdata (store data, right-aligned)
//        -> ldata (extended load data), sdata (store data replicated onto lanes),
//           wmask (byte write enables), misaligned.
module mmio_lane_unit
    import mmio_timer_pkg::*;
(
    input  logic [2:0]  rw_type,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] sdata,
    output logic [3:0]  wmask,
    output logic        misaligned
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[8*lane +: 8];
    assign h = lane[1] ? rdata[31:16] : rdata[15:0];

    // Unsigned-load encodings used as stores behave as their signed-width counterparts.
    always_comb begin
        misaligned = 1'b1;
        ldata      = '0;
        sdata      = wdata;
        wmask      = '0;
        case (rw_type)
            LS_B, LS_BU: begin
                misaligned = 1'b0;
                ldata      = rw_type == LS_B ? {{24{b[7]}}, b} : {24'b0, b};
                sdata      = {4{wdata[7:0]}};
                wmask      = 4'b0001 << lane;
            end
            LS_H, LS_HU: begin
                misaligned = lane[0];
                ldata      = rw_type == LS_H ? {{16{h[15]}}, h} : {16'b0, h};
                sdata      = {2{wdata[15:0]}};
                wmask      = lane[1] ? 4'b1100 : 4'b0011;
            end
            LS_W: begin
                misaligned = lane != 2'b00;
                ldata      = rdata;
                wmask      = 4'b1111;
            end
            default: ;
        endcase
        if (misaligned) begin
            wmask = '0;
            ldata = '0;
        end
    end
endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit timer with compare, sticky match and level irq.
// Ports: clk, rst (async, active-high), bus (slave side of the core data bus), irq (MATCH & IE).
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          PRESC_W   = 16
) (
    input  logic          clk,
    input  logic          rst,
    mmio_timer_if.slave   bus,
    output logic          irq
);
    logic [2:0]         ctrl;
    logic               match;
    logic [31:0]        count;
    logic [31:0]        compare;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;

    logic [5:0]  off;
    logic [31:0] rword, ldata, sdata, nword;
    logic [3:0]  wmask;
    logic        mis, wr, tick, hit, clr;
    logic        wr_ctrl, wr_status, wr_count, wr_compare, wr_presc;

    assign bus.sel = bus.addr[31:8] == BASE_ADDR[31:8];
    assign off     = bus.addr[7:2];

    assign rword = off == OFF_CTRL    ? {29'b0, ctrl}  :
                   off == OFF_STATUS  ? {31'b0, match} :
                   off == OFF_COUNT   ? count          :
                   off == OFF_COMPARE ? compare        :
                   off == OFF_PRESC   ? 32'(presc)     : '0;

    mmio_lane_unit lanes (
        .rw_type    (bus.RW_type),
        .lane       (bus.addr[1:0]),
        .rdata      (rword),
        .wdata      (bus.din),
        .ldata      (ldata),
        .sdata      (sdata),
        .wmask      (wmask),
        .misaligned (mis)
    );

    assign bus.dout = (bus.sel & bus.R_en & ~mis & ~rst) ? ldata : '0;

    // Partial stores merge into the current register value.
    assign wr         = bus.sel & bus.W_en & ~mis;
    assign nword      = (rword & ~byte_mask(wmask)) | (sdata & byte_mask(wmask));
    assign wr_ctrl    = wr & (off == OFF_CTRL);
    assign wr_status  = wr & (off == OFF_STATUS);
    assign wr_count   = wr & (off == OFF_COUNT);
    assign wr_compare = wr & (off == OFF_COMPARE);
    assign wr_presc   = wr & (off == OFF_PRESC);

    assign tick = ctrl[CTRL_EN] & (pcnt == presc);
    // A software COUNT write in the same cycle suppresses the match.
    assign hit  = tick & (count == compare) & ~wr_count;
    assign clr  = wr_status & wmask[0] & sdata[0];
    assign irq  = match & ctrl[CTRL_IE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl    <= '0;
            match   <= 1'b0;
            count   <= '0;
            compare <= '0;
            presc   <= '0;
            pcnt    <= '0;
        end else begin
            if (wr_ctrl) ctrl <= nword[2:0];
            match <= hit | (match & ~clr);
            if (wr_count) count <= nword;
            else if (tick) count <= (hit & ctrl[CTRL_AR]) ? '0 : count + 32'd1;
            if (wr_compare) compare <= nword;
            if (wr_presc) begin
                presc <= nword[PRESC_W-1:0];
                pcnt  <= '0;
            end else if (tick) pcnt <= '0;
            else if (ctrl[CTRL_EN]) pcnt <= pcnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: randomized and directed checks of mmio_timer against a register-level reference model.
// Ports: none (top-level bench).
module tb_mmio_timer;
    import mmio_timer_pkg::*;

    localparam logic [31:0] B = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    mmio_timer_if bus();

    mmio_timer #(.BASE_ADDR(B), .PRESC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .irq (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Model state: 0 CTRL, 1 STATUS, 2 COUNT, 3 COMPARE, 4 PRESC; pc is the prescale phase.
    logic [31:0] m [5];
    int unsigned pc;

    task automatic mreset();
        for (int i = 0; i < 5; i++) m[i] = '0;
        pc = 0;
    endtask

    function automatic bit mis(input logic [2:0] t, input logic [31:0] a);
        case (t)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return a[0];
            3'd2:       return a[1:0] != 2'b00;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic bit inwin(input logic [31:0] a);
        return a[31:8] == B[31:8];
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a, input logic [2:0] t, input bit r);
        logic [31:0] w;
        logic [7:0]  bt;
        logic [15:0] hf;
        int o;
        if (!r || !inwin(a) || mis(t, a)) return '0;
        o  = int'(a[7:2]);
        w  = o < 5 ? m[o] : '0;
        bt = 8'(w >> (8 * a[1:0]));
        hf = 16'(w >> (16 * a[1]));
        case (t)
            3'd0:    return {{24{bt[7]}}, bt};
            3'd4:    return {24'b0, bt};
            3'd1:    return {{16{hf[15]}}, hf};
            3'd5:    return {16'b0, hf};
            default: return w;
        endcase
    endfunction

    task automatic mstep(input bit w, input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
        logic [31:0] old [5];
        logic [31:0] nw;
        bit tick, hit, cw, ok;
        int o, n, l;
        old  = m;
        tick = old[0][0] && pc == old[4];
        hit  = tick && old[2] == old[3];
        cw   = 1'b0;
        if (tick) begin
            pc   = 0;
            m[2] = (hit && old[0][1]) ? 32'd0 : old[2] + 32'd1;
        end else if (old[0][0]) pc++;
        o  = int'(a[7:2]);
        l  = int'(a[1:0]);
        ok = w && inwin(a) && !mis(t, a) && o < 5;
        if (ok) begin
            n  = t[1:0] == 2'd0 ? 1 : t[1:0] == 2'd1 ? 2 : 4;
            nw = old[o];
            for (int k = 0; k < n; k++) nw[8*(l+k) +: 8] = d[8*k +: 8];
            case (o)
                0: m[0] = nw & 32'h7;
                2: begin m[2] = nw; cw = 1'b1; end
                3: m[3] = nw;
                4: begin m[4] = nw & 32'hFFFF; pc = 0; end
                default: ;
            endcase
        end
        if (hit && !cw) m[1] = 32'd1;
        else if (ok && o == 1 && l == 0 && d[0]) m[1] = 32'd0;
    endtask

    task automatic cyc(input bit w, input bit r, input logic [31:0] a, input logic [2:0] t,
                       input logic [31:0] d, output logic [31:0] rd);
        bus.W_en = w; bus.R_en = r; bus.addr = a; bus.RW_type = t; bus.din = d;
        #1;
        check("dout", bus.dout, mread(a, t, r));
        check("sel", 32'(bus.sel), 32'(inwin(a)));
        check("irq", 32'(irq), 32'(m[1][0] & m[0][2]));
        rd = bus.dout;
        mstep(w, a, t, d);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] dummy;

    task automatic wr(input logic [7:0] o, input logic [2:0] t, input logic [31:0] d);
        cyc(1'b1, 1'b0, B + 32'(o), t, d, dummy);
    endtask

    task automatic rdk(input logic [7:0] o, input logic [2:0] t, input logic [31:0] exp, input string tag);
        logic [31:0] v;
        cyc(1'b0, 1'b1, B + 32'(o), t, 32'd0, v);
        check(tag, v, exp);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, B, LS_W, 32'd0, dummy);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  t;
        bit got;
        rst = 1'b1;
        bus.W_en = 0; bus.R_en = 0; bus.addr = 0; bus.RW_type = 0; bus.din = 0;
        mreset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) rdk(8'(4 * i), LS_W, 32'd0, "reset_reg");

        // Basic count: prescale by 4, match at 5 with interrupt enabled.
        wr(8'h10, LS_W, 3);
        wr(8'h0C, LS_W, 5);
        wr(8'h08, LS_W, 0);
        wr(8'h00, LS_W, 5);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            idle();
            got = irq;
        end
        check("basic_irq", 32'(got), 32'd1);
        rdk(8'h08, LS_W, 6, "basic_count6");
        rdk(8'h04, LS_W, 1, "basic_match");

        // Auto-reload sequence and the W1C/set race.
        wr(8'h00, LS_W, 0);
        wr(8'h04, LS_W, 1);
        wr(8'h10, LS_W, 0);
        wr(8'h0C, LS_W, 2);
        wr(8'h08, LS_W, 0);
        wr(8'h00, LS_W, 7);
        for (int i = 0; i < 6; i++) rdk(8'h08, LS_W, 32'(i % 3), "ar_seq");
        wr(8'h04, LS_W, 1);
        rdk(8'h04, LS_W, 0, "w1c_clear");
        check("w1c_irq0", 32'(irq), 0);
        wr(8'h04, LS_W, 1);
        rdk(8'h04, LS_W, 1, "w1c_race");
        check("race_irq1", 32'(irq), 1);
        wr(8'h00, LS_W, 4);
        wr(8'h04, LS_W, 1);
        rdk(8'h04, LS_W, 0, "w1c_late");
        check("late_irq0", 32'(irq), 0);

        // Byte lanes and extension.
        wr(8'h0C, LS_W, 32'h1122_3344);
        wr(8'h0E, LS_B, 32'hAA);
        rdk(8'h0C, LS_W,  32'h11AA_3344, "lane_lw");
        rdk(8'h0E, LS_B,  32'hFFFF_FFAA, "lane_lb");
        rdk(8'h0E, LS_BU, 32'h0000_00AA, "lane_lbu");
        rdk(8'h0C, LS_H,  32'h0000_3344, "lane_lh");
        rdk(8'h0E, LS_HU, 32'h0000_11AA, "lane_lhu");

        // Misaligned and unmapped accesses.
        wr(8'h08, LS_W, 32'h1234);
        wr(8'h09, LS_W, 32'hFFFF_FFFF);
        wr(8'h0D, LS_H, 32'hFFFF);
        wr(8'h0C, 3'b011, 32'hFFFF_FFFF);
        rdk(8'h08, LS_W, 32'h1234, "mis_sw");
        rdk(8'h0C, LS_W, 32'h11AA_3344, "mis_sh");
        rdk(8'h0A, LS_W, 0, "mis_lw");
        rdk(8'h40, LS_W, 0, "unmapped");
        cyc(1'b0, 1'b1, B + 32'h100, LS_W, 0, d);
        check("outside_dout", d, 0);

        // Asynchronous reset mid-count.
        wr(8'h10, LS_W, 0);
        wr(8'h08, LS_W, 32'h55);
        wr(8'h00, LS_W, 1);
        idle();
        bus.R_en = 1'b1; bus.W_en = 1'b0; bus.addr = B + 32'h08; bus.RW_type = LS_W;
        #2 rst = 1'b1;
        #1 check("rst_count", bus.dout, 0);
        check("rst_irq", 32'(irq), 0);
        bus.addr = B;
        #1 check("rst_ctrl", bus.dout, 0);
        rst = 1'b0;
        bus.addr = B + 32'h08;
        #1 check("rst_count_held", bus.dout, 0);
        mreset();
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0: a = B;
                1: a = B + 32'h04;
                2: a = B + 32'h08;
                3: a = B + 32'h0C;
                4: a = B + 32'h10;
                default: a = $urandom_range(0, 3) == 0 ? B + 32'h100 : B + 32'h40;
            endcase
            a = a + 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
            t = $urandom_range(0, 3) == 0 ? 3'($urandom_range(0, 7)) : LS_W;
            case (a[7:2])
                6'h00:   d = 32'($urandom_range(0, 7));
                6'h04:   d = 32'($urandom_range(0, 3));
                default: d = $urandom_range(0, 4) == 0 ? $urandom : 32'($urandom_range(0, 8));
            endcase
            cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, a, t, d, dummy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
